// File: rtl/int_sequencer.sv
// int_sequencer: hardware interrupt entry sequencer sitting ahead of fetch.
// Owns the stack pointer. On a qualified interrupt it freezes fetch and waits
// for the pipeline to drain. It then pushes PC[31:16], PC[15:0] and CCR,
// reads a two-word vector and redirects fetch with a one-cycle pc_load strobe.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   irq_in               external interrupt level (edge-detected internally)
//   ie, stall_in         acceptance qualifiers (enable, load-use stall)
//   pc_in, ccr_in        resume PC and flags, captured at acceptance
//   sp_wr, sp_wr_data    pipeline SP update, honoured only while idle
//   mem_rdata            data-memory read data (1-cycle latency)
//   freeze               holds fetch and forces bubbles for the whole sequence
//   busy                 sequencer owns the data-memory port
//   mem_wr/rd/addr/wdata data-memory request
//   pc_load, pc_new      fetch redirect strobe and target
//   int_ack              acknowledge pulse, coincident with pc_load
//   sp_out, stack_ovf    current SP, sticky push-wrap flag
module int_sequencer #(
   parameter int unsigned    AW           = 12,
   parameter logic [AW-1:0]  SP_RESET     = AW'(12'hFFF),
   parameter logic [AW-1:0]  VEC_ADDR     = AW'(12'h000),
   parameter int unsigned    DRAIN_CYCLES = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          irq_in,
   input  logic          ie,
   input  logic          stall_in,
   input  logic [31:0]   pc_in,
   input  logic [2:0]    ccr_in,
   input  logic          sp_wr,
   input  logic [AW-1:0] sp_wr_data,
   input  logic [15:0]   mem_rdata,
   output logic          freeze,
   output logic          busy,
   output logic          mem_wr,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   output logic          pc_load,
   output logic [31:0]   pc_new,
   output logic          int_ack,
   output logic [AW-1:0] sp_out,
   output logic          stack_ovf
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StPushH,
      StPushL,
      StPushC,
      StVecH,
      StVecL,
      StLoad
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] sp_q, sp_d;
   logic          irq_q;
   logic          pending_q, pending_d;
   logic          ovf_q, ovf_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   pc_cap_q, pc_cap_d;
   logic [2:0]    ccr_cap_q, ccr_cap_d;
   logic [15:0]   vec_hi_q, vec_hi_d;
   logic [31:0]   pc_new_q, pc_new_d;
   logic          push;
   logic [15:0]   push_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sp_q      <= SP_RESET;
         irq_q     <= 1'b0;
         pending_q <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= 4'd0;
         pc_cap_q  <= 32'd0;
         ccr_cap_q <= 3'd0;
         vec_hi_q  <= 16'd0;
         pc_new_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         irq_q     <= irq_in;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
         pc_cap_q  <= pc_cap_d;
         ccr_cap_q <= ccr_cap_d;
         vec_hi_q  <= vec_hi_d;
         pc_new_q  <= pc_new_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      // One-deep latch: an edge while already pending is simply absorbed.
      pending_d = pending_q | (irq_in & ~irq_q);
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      pc_cap_d  = pc_cap_q;
      ccr_cap_d = ccr_cap_q;
      vec_hi_d  = vec_hi_q;
      pc_new_d  = pc_new_q;

      freeze    = (state_q != StIdle);
      busy      = 1'b0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 16'd0;
      pc_load   = 1'b0;
      int_ack   = 1'b0;
      pc_new    = pc_new_q;
      push      = 1'b0;
      push_data = 16'd0;

      unique case (state_q)
         StIdle: begin
            // SP load lands first, so an acceptance in this same cycle pushes
            // relative to the newly written SP.
            if (sp_wr) begin
               sp_d = sp_wr_data;
            end
            if (pending_q && ie && !stall_in) begin
               pc_cap_d  = pc_in;
               ccr_cap_d = ccr_in;
               cnt_d     = DRAIN_LOAD;
               pending_d = 1'b0;
               state_d   = StDrain;
            end
         end
         StDrain: begin
            if (cnt_q == 4'd0) begin
               state_d = StPushH;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StPushH: begin
            busy      = 1'b1;
            push      = 1'b1;
            push_data = pc_cap_q[31:16];
            state_d   = StPushL;
         end
         StPushL: begin
            busy      = 1'b1;
            push      = 1'b1;
            push_data = pc_cap_q[15:0];
            state_d   = StPushC;
         end
         StPushC: begin
            busy      = 1'b1;
            push      = 1'b1;
            push_data = {13'd0, ccr_cap_q};
            state_d   = StVecH;
         end
         StVecH: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = VEC_ADDR;
            state_d  = StVecL;
         end
         StVecL: begin
            busy     = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = VEC_ADDR + AW'(1);
            // Read data for the VEC_H request arrives this cycle.
            vec_hi_d = mem_rdata;
            state_d  = StLoad;
         end
         StLoad: begin
            busy     = 1'b1;
            pc_new   = {vec_hi_q, mem_rdata};
            pc_new_d = {vec_hi_q, mem_rdata};
            pc_load  = 1'b1;
            int_ack  = 1'b1;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Shared push datapath; a push at SP=0 wraps and flags overflow but the
      // sequence carries on.
      if (push) begin
         mem_wr    = 1'b1;
         mem_addr  = sp_q;
         mem_wdata = push_data;
         sp_d      = sp_q - AW'(1);
         if (sp_q == '0) begin
            ovf_d = 1'b1;
         end
      end
   end

   assign sp_out    = sp_q;
   assign stack_ovf = ovf_q;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        irq_in;
   logic        ie;
   logic        stall_in;
   logic [31:0] pc_in;
   logic [2:0]  ccr_in;
   logic        sp_wr;
   logic [11:0] sp_wr_data;
   logic [15:0] mem_rdata = 16'h0000;
   logic        freeze;
   logic        busy;
   logic        mem_wr;
   logic        mem_rd;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        pc_load;
   logic [31:0] pc_new;
   logic        int_ack;
   logic [11:0] sp_out;
   logic        stack_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   // Vector words held by the bench's memory model at addresses 0 and 1.
   logic [15:0] vec0 = 16'h0000;
   logic [15:0] vec1 = 16'h0200;

   int_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .ie         (ie),
      .stall_in   (stall_in),
      .pc_in      (pc_in),
      .ccr_in     (ccr_in),
      .sp_wr      (sp_wr),
      .sp_wr_data (sp_wr_data),
      .mem_rdata  (mem_rdata),
      .freeze     (freeze),
      .busy       (busy),
      .mem_wr     (mem_wr),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .pc_load    (pc_load),
      .pc_new     (pc_new),
      .int_ack    (int_ack),
      .sp_out     (sp_out),
      .stack_ovf  (stack_ovf)
   );

   always #5 clk = ~clk;

   // 1-cycle-latency read port over the vector words.
   always @(posedge clk) begin
      if (mem_addr == 12'h000)      mem_rdata <= vec0;
      else if (mem_addr == 12'h001) mem_rdata <= vec1;
      else                          mem_rdata <= 16'h0000;
   end

   initial begin
      #200000;
      $error("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_irq();
      irq_in = 1'b1;
      tick();
      irq_in = 1'b0;
   endtask

   // Entered in the acceptance cycle; returns in the LOAD cycle.
   task automatic run_seq(input logic [11:0] sp0, input logic [31:0] pc, input logic [2:0] ccr,
                          input logic [31:0] tgt, input bit irq_mid);
      logic [11:0] s1, s2, s3;
      s1 = sp0 - 12'd1;
      s2 = sp0 - 12'd2;
      s3 = sp0 - 12'd3;
      chk("accept_nofreeze", {31'd0, freeze}, 32'd0);
      tick();
      sp_wr = 1'b0;
      pc_in = ~pc;
      ccr_in = ~ccr;
      for (int d = 0; d < 3; d++) begin
         chk("drain_freeze", {31'd0, freeze}, 32'd1);
         chk("drain_busy", {31'd0, busy}, 32'd0);
         chk("drain_wr", {31'd0, mem_wr}, 32'd0);
         tick();
      end
      chk("pushh_wr", {31'd0, mem_wr}, 32'd1);
      chk("pushh_busy", {31'd0, busy}, 32'd1);
      chk("pushh_addr", {20'd0, mem_addr}, {20'd0, sp0});
      chk("pushh_data", {16'd0, mem_wdata}, {16'd0, pc[31:16]});
      tick();
      chk("pushl_wr", {31'd0, mem_wr}, 32'd1);
      chk("pushl_addr", {20'd0, mem_addr}, {20'd0, s1});
      chk("pushl_data", {16'd0, mem_wdata}, {16'd0, pc[15:0]});
      if (irq_mid) irq_in = 1'b1;
      tick();
      irq_in = 1'b0;
      chk("pushc_wr", {31'd0, mem_wr}, 32'd1);
      chk("pushc_addr", {20'd0, mem_addr}, {20'd0, s2});
      chk("pushc_data", {16'd0, mem_wdata}, {29'd0, ccr});
      tick();
      chk("vech_rd", {31'd0, mem_rd}, 32'd1);
      chk("vech_wr", {31'd0, mem_wr}, 32'd0);
      chk("vech_addr", {20'd0, mem_addr}, 32'h000);
      tick();
      chk("vecl_rd", {31'd0, mem_rd}, 32'd1);
      chk("vecl_addr", {20'd0, mem_addr}, 32'h001);
      chk("vecl_noload", {31'd0, pc_load}, 32'd0);
      tick();
      chk("load_strobe", {31'd0, pc_load}, 32'd1);
      chk("load_ack", {31'd0, int_ack}, 32'd1);
      chk("load_pc_new", pc_new, tgt);
      chk("load_rd", {31'd0, mem_rd}, 32'd0);
      chk("load_freeze", {31'd0, freeze}, 32'd1);
      chk("load_sp", {20'd0, sp_out}, {20'd0, s3});
   endtask

   task automatic chk_idle(input logic [31:0] tgt, input logic [11:0] sp);
      chk("idle_freeze", {31'd0, freeze}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_pc_load", {31'd0, pc_load}, 32'd0);
      chk("idle_ack", {31'd0, int_ack}, 32'd0);
      chk("idle_pc_new_hold", pc_new, tgt);
      chk("idle_sp", {20'd0, sp_out}, {20'd0, sp});
   endtask

   initial begin
      rst        = 1'b1;
      irq_in     = 1'b0;
      ie         = 1'b0;
      stall_in   = 1'b0;
      pc_in      = 32'd0;
      ccr_in     = 3'd0;
      sp_wr      = 1'b0;
      sp_wr_data = 12'd0;
      tick();
      tick();

      // Reset state
      chk("rst_freeze", {31'd0, freeze}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_addr", {20'd0, mem_addr}, 32'd0);
      chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
      chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
      chk("rst_pc_new", pc_new, 32'd0);
      chk("rst_ack", {31'd0, int_ack}, 32'd0);
      chk("rst_sp", {20'd0, sp_out}, 32'hFFF);
      chk("rst_ovf", {31'd0, stack_ovf}, 32'd0);
      rst = 1'b0;
      tick();
      tick();

      // Basic service
      ie     = 1'b1;
      pc_in  = 32'h0001_0040;
      ccr_in = 3'b101;
      pulse_irq();
      run_seq(12'hFFF, 32'h0001_0040, 3'b101, 32'h0000_0200, 1'b0);
      tick();
      chk_idle(32'h0000_0200, 12'hFFC);
      tick();

      // Gating by ie: pending is retained until ie rises
      ie = 1'b0;
      pulse_irq();
      tick();
      chk("ie0_nofreeze_a", {31'd0, freeze}, 32'd0);
      tick();
      chk("ie0_nofreeze_b", {31'd0, freeze}, 32'd0);
      ie     = 1'b1;
      pc_in  = 32'h1234_5678;
      ccr_in = 3'b010;
      run_seq(12'hFFC, 32'h1234_5678, 3'b010, 32'h0000_0200, 1'b0);
      tick();
      chk_idle(32'h0000_0200, 12'hFF9);

      // stall_in delays acceptance by two cycles
      stall_in = 1'b1;
      pc_in    = 32'hCAFE_0007;
      ccr_in   = 3'b111;
      pulse_irq();
      tick();
      chk("stall_nofreeze_a", {31'd0, freeze}, 32'd0);
      tick();
      chk("stall_nofreeze_b", {31'd0, freeze}, 32'd0);
      stall_in = 1'b0;
      run_seq(12'hFF9, 32'hCAFE_0007, 3'b111, 32'h0000_0200, 1'b0);
      tick();
      chk_idle(32'h0000_0200, 12'hFF6);

      // Back-to-back: second edge during PUSH_L
      sp_wr      = 1'b1;
      sp_wr_data = 12'hFFF;
      tick();
      sp_wr = 1'b0;
      chk("spwr_load", {20'd0, sp_out}, 32'hFFF);
      pc_in  = 32'h0003_0010;
      ccr_in = 3'b001;
      pulse_irq();
      run_seq(12'hFFF, 32'h0003_0010, 3'b001, 32'h0000_0200, 1'b1);
      tick();
      chk("b2b_idle_gap", {31'd0, freeze}, 32'd0);
      pc_in  = 32'h0004_0020;
      ccr_in = 3'b110;
      run_seq(12'hFFC, 32'h0004_0020, 3'b110, 32'h0000_0200, 1'b0);
      tick();
      chk_idle(32'h0000_0200, 12'hFF9);

      // SP wrap: pushes at 001, 000, FFF
      chk("ovf_clear_before", {31'd0, stack_ovf}, 32'd0);
      sp_wr      = 1'b1;
      sp_wr_data = 12'h001;
      tick();
      sp_wr  = 1'b0;
      pc_in  = 32'h00AB_00CD;
      ccr_in = 3'b011;
      pulse_irq();
      run_seq(12'h001, 32'h00AB_00CD, 3'b011, 32'h0000_0200, 1'b0);
      chk("ovf_set", {31'd0, stack_ovf}, 32'd1);
      tick();
      chk_idle(32'h0000_0200, 12'hFFE);
      tick();
      chk("ovf_sticky", {31'd0, stack_ovf}, 32'd1);

      // SP load in the acceptance cycle, new vector contents
      vec0   = 16'h0001;
      vec1   = 16'h8000;
      pc_in  = 32'h0000_1111;
      ccr_in = 3'b100;
      pulse_irq();
      sp_wr      = 1'b1;
      sp_wr_data = 12'h800;
      run_seq(12'h800, 32'h0000_1111, 3'b100, 32'h0001_8000, 1'b0);
      tick();
      chk_idle(32'h0001_8000, 12'h7FD);
      chk("ovf_still_sticky", {31'd0, stack_ovf}, 32'd1);

      // Reset during PUSH_L
      pc_in  = 32'h0005_0050;
      ccr_in = 3'b010;
      pulse_irq();
      tick();
      tick();
      tick();
      tick();
      chk("pre_rst_pushh", {31'd0, mem_wr}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_freeze", {31'd0, freeze}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_wr", {31'd0, mem_wr}, 32'd0);
      chk("midrst_sp", {20'd0, sp_out}, 32'hFFF);
      chk("midrst_ovf", {31'd0, stack_ovf}, 32'd0);
      chk("midrst_pc_new", pc_new, 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("postrst_nowr", {31'd0, mem_wr}, 32'd0);
         chk("postrst_nofreeze", {31'd0, freeze}, 32'd0);
         tick();
      end

      // Normal full sequence after reset
      pc_in  = 32'h0006_0060;
      ccr_in = 3'b001;
      pulse_irq();
      run_seq(12'hFFF, 32'h0006_0060, 3'b001, 32'h0001_8000, 1'b0);
      tick();
      chk_idle(32'h0001_8000, 12'hFFC);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
